// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU function codes, fetch FSM states and
// instruction field positions. Imported by the fetch stage and the decoder.
package cpu_pkg;

  // Instruction field layout: cmd occupies the top CMD_W bits, the jump
  // target sits at the bottom of the word.
  localparam int unsigned CMD_W   = 6;
  localparam int unsigned TGT_LSB = 0;

  // Opcodes (cmd field), shared with the decoder
  localparam logic [CMD_W-1:0] OP_NOP = 6'h00;
  localparam logic [CMD_W-1:0] OP_ADD = 6'h01;
  localparam logic [CMD_W-1:0] OP_SUB = 6'h02;
  localparam logic [CMD_W-1:0] OP_AND = 6'h03;
  localparam logic [CMD_W-1:0] OP_OR  = 6'h04;
  localparam logic [CMD_W-1:0] OP_XOR = 6'h05;
  localparam logic [CMD_W-1:0] OP_LD  = 6'h06;
  localparam logic [CMD_W-1:0] OP_ST  = 6'h07;
  localparam logic [CMD_W-1:0] OP_BZ  = 6'h08;
  localparam logic [CMD_W-1:0] OP_J   = 6'h09;
  localparam logic [CMD_W-1:0] OP_MOV = 6'h0A;

  // ALU function codes
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5
  } alu_func_t;

  // Fetch stage states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  // Next-pc selection
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_JUMP = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus the
// instruction-register handshake towards decode.
//   master : fetch stage (drives requests and the presented instruction)
//   slave  : memory + decode side
interface instr_fetch_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
);
  import cpu_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               ir_valid;
  logic               ir_ready;
  logic [INSTR_W-1:0] ir_instr;
  logic [CMD_W-1:0]   ir_cmd;
  logic [PC_W-1:0]    ir_pc;
  logic               pc_ctrl;

  modport master (
    output imem_req_valid, imem_req_addr, ir_valid, ir_instr, ir_cmd, ir_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready, pc_ctrl
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, ir_valid, ir_instr, ir_cmd, ir_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready, pc_ctrl
  );

endinterface

// File: rtl/cpu_pc_gen.sv
// Program counter with hold / increment / jump selection.
//   clk, rst_n : clock, async active-low reset (loads RESET_PC)
//   i_sel      : next-pc select
//   i_target   : jump target
//   o_pc       : current pc
module cpu_pc_gen
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_t         i_sel,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // Increment wraps naturally modulo 2^PC_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      case (i_sel)
        PC_INC:  r_pc <= r_pc + PC_W'(1);
        PC_JUMP: r_pc <= i_target;
        default: r_pc <= r_pc;
      endcase
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue stage: owns the pc, fetches one instruction at a
// time over the memory request/response bus and presents it to decode.
//   clk, rst_n  : clock, async active-low reset
//   en          : run enable (level)
//   bus         : memory request/response and instruction-register handshake
//   retired_cnt : saturating count of consumed instructions
//   proto_err   : sticky, memory response seen outside WAIT
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  instr_fetch_if.master    bus,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             proto_err
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic               r_req_valid;
  logic               r_ir_valid;
  logic               w_req_valid_nxt;
  logic               w_ir_valid_nxt;
  pc_sel_t            w_pc_sel;
  logic [PC_W-1:0]    w_pc;
  logic [INSTR_W-1:0] r_ir_instr;
  logic [PC_W-1:0]    r_ir_pc;
  logic [CNT_W-1:0]   r_retired;
  logic               r_proto_err;
  logic               w_ir_fire;
  logic               w_rsp_take;

  assign w_ir_fire  = (r_state == ST_HOLD) && bus.ir_ready;
  assign w_rsp_take = (r_state == ST_WAIT) && bus.imem_rsp_valid;

  // State register; valids are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_ir_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_ir_valid  <= w_ir_valid_nxt;
    end
  end

  // Next state; en is only sampled in IDLE and at the HOLD handshake
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en)                 w_state_nxt = ST_REQ;
      ST_REQ:  if (bus.imem_req_ready) w_state_nxt = ST_WAIT;
      ST_WAIT: if (bus.imem_rsp_valid) w_state_nxt = ST_HOLD;
      ST_HOLD: if (bus.ir_ready)       w_state_nxt = en ? ST_REQ : ST_IDLE;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_req_valid_nxt = (w_state_nxt == ST_REQ);
    w_ir_valid_nxt  = (w_state_nxt == ST_HOLD);
    w_pc_sel        = PC_HOLD;
    if (w_ir_fire) begin
      w_pc_sel = bus.pc_ctrl ? PC_JUMP : PC_INC;
    end
  end

  cpu_pc_gen #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sel    (w_pc_sel),
    .i_target (r_ir_instr[TGT_LSB +: PC_W]),
    .o_pc     (w_pc)
  );

  // Instruction register, retired counter, protocol error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_instr  <= '0;
      r_ir_pc     <= '0;
      r_retired   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_rsp_take) begin
        r_ir_instr <= bus.imem_rsp_data;
        r_ir_pc    <= w_pc;
      end
      if (w_ir_fire && (r_retired != '1)) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (bus.imem_rsp_valid && (r_state != ST_WAIT)) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_req_addr  = w_pc;
  assign bus.ir_valid       = r_ir_valid;
  assign bus.ir_instr       = r_ir_instr;
  assign bus.ir_cmd         = r_ir_instr[INSTR_W-1 -: CMD_W];
  assign bus.ir_pc          = r_ir_pc;
  assign retired_cnt        = r_retired;
  assign proto_err          = r_proto_err;

endmodule
